// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and pixel addressing for the convolution8 pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_DIM    = 8;
  localparam int KER_DIM    = 3;
  localparam int FM_DIM     = IMG_DIM - KER_DIM + 1;  // 6x6 convolution output
  localparam int POOL_DIM   = 3;                      // pooled map side
  localparam int POOL_SIZE  = FM_DIM / POOL_DIM;      // 2x2 window, stride 2

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POOL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // MSB bit index of pixel (row,col) in a flattened dim x dim map, row-major, pixel 0 at the top.
  function automatic int pix_msb(input int row, input int col, input int dim,
                                 input int dw = DATA_WIDTH);
    return dim * dim * dw - 1 - (row * dim + col) * dw;
  endfunction

endpackage

// File: rtl/max4_unit.sv
// Unsigned maximum of four pixels through a two-level comparator tree.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module max4_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] pix0,
  input  logic [DATA_WIDTH-1:0] pix1,
  input  logic [DATA_WIDTH-1:0] pix2,
  input  logic [DATA_WIDTH-1:0] pix3,
  output logic [DATA_WIDTH-1:0] pix_max
);

  logic [DATA_WIDTH-1:0] max01;
  logic [DATA_WIDTH-1:0] max23;

  // Pairwise compare, then compare the two winners; ties pass the shared value.
  always_comb begin
    max01   = (pix0 >= pix1) ? pix0 : pix1;
    max23   = (pix2 >= pix3) ? pix2 : pix3;
    pix_max = (max01 >= max23) ? max01 : max23;
  end

endmodule

// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 max pooling of a 6x6 feature map into a 3x3 map, one window per clock.
// Latency: frame accepted at E0, windows at E1..E9, out_valid from E9; 11-cycle minimum period.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so frames stall upstream.
module maxpool2x2_stage #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int IN_DIM     = conv_pkg::FM_DIM,
  parameter int POOL       = conv_pkg::POOL_SIZE
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [IN_DIM*IN_DIM*DATA_WIDTH-1:0]                 i_featuremap,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [(IN_DIM/POOL)*(IN_DIM/POOL)*DATA_WIDTH-1:0]   pooled_fm
);

  import conv_pkg::*;

  localparam int OUT_DIM = IN_DIM / POOL;
  localparam int NWIN    = OUT_DIM * OUT_DIM;
  localparam int FW      = IN_DIM * IN_DIM * DATA_WIDTH;
  localparam int PW      = NWIN * DATA_WIDTH;

  state_e            state_q, state_d;
  logic [3:0]        win_cnt_q, win_cnt_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [PW-1:0]     pooled_q, pooled_d;

  int                win_row;
  int                win_col;
  logic [DATA_WIDTH-1:0] op0, op1, op2, op3, win_max;

  // Select the four pixels of the window addressed by win_cnt.
  always_comb begin
    win_row = int'(win_cnt_q) / OUT_DIM;
    win_col = int'(win_cnt_q) % OUT_DIM;
    op0 = frame_q[pix_msb(win_row*POOL,     win_col*POOL,     IN_DIM, DATA_WIDTH) -: DATA_WIDTH];
    op1 = frame_q[pix_msb(win_row*POOL,     win_col*POOL + 1, IN_DIM, DATA_WIDTH) -: DATA_WIDTH];
    op2 = frame_q[pix_msb(win_row*POOL + 1, win_col*POOL,     IN_DIM, DATA_WIDTH) -: DATA_WIDTH];
    op3 = frame_q[pix_msb(win_row*POOL + 1, win_col*POOL + 1, IN_DIM, DATA_WIDTH) -: DATA_WIDTH];
  end

  max4_unit #(.DATA_WIDTH(DATA_WIDTH)) u_max4 (
    .pix0    (op0),
    .pix1    (op1),
    .pix2    (op2),
    .pix3    (op3),
    .pix_max (win_max)
  );

  // Next-state and datapath update: capture in IDLE, one window per cycle in POOL, hold in DONE.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    frame_d   = frame_q;
    pooled_d  = pooled_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          frame_d   = i_featuremap;
          pooled_d  = '0;
          win_cnt_d = 4'd0;
          state_d   = ST_POOL;
        end
      end
      ST_POOL: begin
        pooled_d[pix_msb(win_row, win_col, OUT_DIM, DATA_WIDTH) -: DATA_WIDTH] = win_max;
        if (win_cnt_q == 4'(NWIN - 1)) begin
          win_cnt_d = 4'd0;
          state_d   = ST_DONE;
        end else begin
          win_cnt_d = win_cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial or pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= 4'd0;
      frame_q   <= '0;
      pooled_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      frame_q   <= frame_d;
      pooled_q  <= pooled_d;
    end
  end

  // Handshake outputs decode state only, so there is no input-to-output combinational path.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    pooled_fm = pooled_q;
  end

endmodule

// File: tb/tb_maxpool2x2_stage.sv
// Self-checking bench for maxpool2x2_stage: vector table plus reset, backpressure and back-to-back sequences.
// Expected results are queued at frame acceptance and compared when the output handshake occurs.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_maxpool2x2_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [287:0] i_featuremap;
  logic         out_valid;
  logic         out_ready;
  logic [71:0]  pooled_fm;

  always #5 clk = ~clk;

  maxpool2x2_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .i_featuremap (i_featuremap),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pooled_fm    (pooled_fm)
  );

  typedef struct {
    logic [287:0] frame;
    logic [71:0]  exp;
  } vec_t;

  typedef struct {
    logic [71:0] exp;
    int          acc;
  } sb_t;

  sb_t  sb[$];
  sb_t  sb_head;
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_prev = -1;
  int   acc_last = -1;
  logic prev_valid = 1'b0;

  logic [287:0] ramp_f, corner_f, ff_f, rnd_f;
  logic [71:0]  ramp_e, corner_e, hold_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference max-pool, written independently from the frame layout description.
  function automatic logic [71:0] model(input logic [287:0] f);
    logic [71:0] r;
    logic [7:0]  m;
    logic [7:0]  p;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        m = 8'h00;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            p = f[287 - ((2*i + dr)*6 + 2*j + dc)*8 -: 8];
            if (p > m) m = p;
          end
        end
        r[71 - (i*3 + j)*8 -: 8] = m;
      end
    end
    return r;
  endfunction

  function automatic logic [287:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output side of the scoreboard: latency on the rising edge of out_valid, data on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=1 expected=0 (t=%0t)", $time);
        end else begin
          check("latency", 72'(cyc - sb[0].acc), 72'd10);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        sb_head = sb.pop_front();
        check("pooled_fm", pooled_fm, sb_head.exp);
      end
      prev_valid = out_valid;
    end
  end

  // Present a frame and wait (bounded) for acceptance; the expected result is queued at acceptance.
  task automatic drive_frame(input logic [287:0] f, input logic [71:0] e, input bit hold);
    bit done;
    done = 1'b0;
    i_featuremap = f;
    in_valid     = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp: e, acc: cyc});
        acc_prev = acc_last;
        acc_last = cyc;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 72'(sb.size()), 72'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    i_featuremap = '0;

    // Reset held low with random activity on the inputs.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      i_featuremap = rand_frame();
      in_valid     = 1'($urandom_range(0, 1));
      out_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out_valid", 72'(out_valid), 72'd0);
      check("rst_pooled", pooled_fm, 72'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_in_ready", 72'(in_ready), 72'd1);
      @(posedge clk);
      #1;
    end

    // Vector table.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        ramp_f[287 - (r*6 + c)*8 -: 8] = 8'(r*6 + c);
    ramp_e = 72'h07_09_0B_13_15_17_1F_21_23;
    corner_f = '0;
    corner_f[287 -: 8] = 8'hAB;
    corner_f[7:0]      = 8'hCD;
    corner_f[167 -: 8] = 8'hFF;
    corner_e = 72'hAB_00_00_00_FF_00_00_00_CD;
    ff_f = '1;
    tbl[0] = '{frame: ramp_f,   exp: ramp_e};
    tbl[1] = '{frame: corner_f, exp: corner_e};
    tbl[2] = '{frame: ff_f,     exp: 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF};
    rnd_f  = rand_frame();
    tbl[3] = '{frame: rnd_f,    exp: model(rnd_f)};
    rnd_f  = rand_frame();
    tbl[4] = '{frame: rnd_f,    exp: model(rnd_f)};
    for (int i = 0; i < 5; i++) begin
      drive_frame(tbl[i].frame, tbl[i].exp, 1'b0);
      wait_drain();
      check("in_ready_after_frame", 72'(in_ready), 72'd1);
    end

    // Backpressure in DONE: result held, input side closed, in_valid pulses ignored.
    out_ready = 1'b0;
    drive_frame(ramp_f, ramp_e, 1'b0);
    for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
    check("bp_reached_done", 72'(out_valid), 72'd1);
    hold_v = pooled_fm;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k % 2 == 0);
      @(negedge clk);
      check("bp_out_valid", 72'(out_valid), 72'd1);
      check("bp_stable", pooled_fm, hold_v);
      check("bp_in_ready", 72'(in_ready), 72'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_back_idle", 72'(in_ready), 72'd1);
    check("bp_sb_empty", 72'(sb.size()), 72'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of pooling.
    drive_frame(ramp_f, ramp_e, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("partial_nonzero", 72'(pooled_fm != 72'd0), 72'd1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 72'(out_valid), 72'd0);
    check("midrst_pooled", pooled_fm, 72'd0);
    check("midrst_in_ready", 72'(in_ready), 72'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_frame(ramp_f, ramp_e, 1'b0);
    wait_drain();

    // Back-to-back frames with in_valid and out_ready held high.
    rnd_f = rand_frame();
    drive_frame(rnd_f, model(rnd_f), 1'b1);
    drive_frame(ff_f, 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF, 1'b1);
    in_valid = 1'b0;
    check("b2b_spacing", 72'(acc_last - acc_prev), 72'd11);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
